// File: rtl/smallcalc_pkg.sv
// ---------------------------------------------------------------------------
// smallcalc_pkg
// Definitions shared by the keypad front end of the small calculator:
//   - kp_state_e : scanner FSM encoding (SCAN, DEBOUNCE, HELD)
//   - COLSEL_*   : one-cold column drive patterns (active-low columns)
//   - ROWS_IDLE  : row lines with no key pressed (all pulled up)
//   - helpers to decode a column index and to classify a row sample
// ---------------------------------------------------------------------------
package smallcalc_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } kp_state_e;

  // One-cold column drive patterns, column 0 is bit 0.
  localparam logic [3:0] COLSEL_0 = 4'b1110;
  localparam logic [3:0] COLSEL_1 = 4'b1101;
  localparam logic [3:0] COLSEL_2 = 4'b1011;
  localparam logic [3:0] COLSEL_3 = 4'b0111;

  // Rows read back all high when nothing in the driven column is pressed.
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Column index to one-cold drive pattern.
  function automatic logic [3:0] colsel_of(input logic [1:0] col);
    logic [3:0] pattern;
    case (col)
      2'd0:    pattern = COLSEL_0;
      2'd1:    pattern = COLSEL_1;
      2'd2:    pattern = COLSEL_2;
      default: pattern = COLSEL_3;
    endcase
    return pattern;
  endfunction

  // A sample counts as a press only when exactly one row is pulled low;
  // several low rows mean ghosting or a multi-key chord and are ignored.
  function automatic logic single_low(input logic [3:0] rows);
    logic hit;
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Index of the low row; only meaningful when single_low() is true.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage : smallcalc_pkg

// File: rtl/keypad_sync.sv
// ---------------------------------------------------------------------------
// keypad_sync
// Two-flop synchronizer for the asynchronous keypad row lines.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset (flops go to all ones)
//   d_i  - raw row lines, asynchronous to clk
//   q_o  - synchronized row lines (two clk cycles of latency)
// ---------------------------------------------------------------------------
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: rows are active-low, so resetting to all ones means "no key
  // pressed"; a zero reset value would look like every key held at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old
      // values on the same edge, giving a true two-stage chain.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : keypad_sync

// File: rtl/keypad_scan.sv
// ---------------------------------------------------------------------------
// keypad_scan
// 4x4 matrix keypad scanner with press/release debouncing.
// One column is driven low at a time for SCAN_DIV cycles (the dwell); the
// synchronized rows are sampled on the last cycle of each dwell. A single
// low row starts debouncing with the column frozen; DEBOUNCE_SCANS matching
// samples accept the key, and DEBOUNCE_SCANS all-high samples release it.
// Parameters:
//   SCAN_DIV       - dwell length in clk cycles (4..65535)
//   DEBOUNCE_SCANS - matching samples needed for press and release (1..15)
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   ROWIN      - row lines, active-low, asynchronous
//   COLSEL     - column drive, active-low, exactly one bit low
//   KEYCODE    - row*4 + col of the last accepted key
//   KEY_VALID  - one-cycle pulse when a key is accepted
//   KEY_HELD   - high from acceptance until the release is accepted
// ---------------------------------------------------------------------------
module keypad_scan
  import smallcalc_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ROWIN,
  output logic [3:0] COLSEL,
  output logic [3:0] KEYCODE,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  localparam logic [15:0] DWELL_LAST   = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  MATCH_TARGET = 4'(DEBOUNCE_SCANS);

  // -------------------------------------------------------------------------
  // Row synchronizer
  // -------------------------------------------------------------------------
  logic [3:0] rows_s;

  keypad_sync #(
    .WIDTH (4)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ROWIN),
    .q_o (rows_s)
  );

  logic       press_ok;
  logic [1:0] press_row;

  assign press_ok  = single_low(rows_s);
  assign press_row = low_row(rows_s);

  // -------------------------------------------------------------------------
  // Dwell counter: free-running in every state so the sample cadence never
  // changes while debouncing or holding.
  // -------------------------------------------------------------------------
  logic [15:0] dwell_q, dwell_d;
  logic        sample;

  assign sample  = (dwell_q == DWELL_LAST);
  assign dwell_d = sample ? 16'd0 : dwell_q + 16'd1;

  // -------------------------------------------------------------------------
  // Scanner state
  // -------------------------------------------------------------------------
  kp_state_e  state_q,     state_d;
  logic [1:0] col_q,       col_d;
  logic [3:0] colsel_q,    colsel_d;
  logic [1:0] cand_row_q,  cand_row_d;
  logic [3:0] match_q,     match_d;
  logic [3:0] release_q,   release_d;
  logic [3:0] keycode_q,   keycode_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q,  key_held_d;

  // -------------------------------------------------------------------------
  // Next-state logic. Every decision happens at a sample point; between
  // samples everything holds except the one-cycle KEY_VALID pulse.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    col_d       = col_q;
    cand_row_d  = cand_row_q;
    match_d     = match_q;
    release_d   = release_q;
    keycode_d   = keycode_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (sample) begin
      unique case (state_q)
        ST_SCAN: begin
          if (press_ok) begin
            // Freeze on this column and start counting matches.
            cand_row_d = press_row;
            match_d    = 4'd1;
            if (MATCH_TARGET == 4'd1) begin
              keycode_d   = {press_row, col_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              release_d   = 4'd0;
              state_d     = ST_HELD;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (press_ok && (press_row == cand_row_q)) begin
            match_d = match_q + 4'd1;
            if ((match_q + 4'd1) == MATCH_TARGET) begin
              keycode_d   = {cand_row_q, col_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              release_d   = 4'd0;
              state_d     = ST_HELD;
            end
          end else begin
            // Bounce or a different row: give up and move past this column.
            match_d = 4'd0;
            state_d = ST_SCAN;
            col_d   = col_q + 2'd1;
          end
        end

        ST_HELD: begin
          if (rows_s == ROWS_IDLE) begin
            if ((release_q + 4'd1) == MATCH_TARGET) begin
              release_d  = 4'd0;
              match_d    = 4'd0;
              key_held_d = 1'b0;
              state_d    = ST_SCAN;
              col_d      = col_q + 2'd1;
            end else begin
              release_d = release_q + 4'd1;
            end
          end else begin
            // Any low row (the held key or another) restarts the release run.
            release_d = 4'd0;
          end
        end

        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  // Column drive is registered so COLSEL never glitches through two low bits.
  assign colsel_d = colsel_of(col_d);

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_q     <= 16'd0;
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      colsel_q    <= COLSEL_0;
      cand_row_q  <= 2'd0;
      match_q     <= 4'd0;
      release_q   <= 4'd0;
      keycode_q   <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      state_q     <= state_d;
      col_q       <= col_d;
      colsel_q    <= colsel_d;
      cand_row_q  <= cand_row_d;
      match_q     <= match_d;
      release_q   <= release_d;
      keycode_q   <= keycode_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign COLSEL    = colsel_q;
  assign KEYCODE   = keycode_q;
  assign KEY_VALID = key_valid_q;
  assign KEY_HELD  = key_held_q;

endmodule : keypad_scan

// File: tb/tb_keypad_scan.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=2.
// Cycle n is the interval following the n-th rising edge after reset is
// released; the dwell counter equals n%4, so sample points are at n=3,7,11...
// The synchronized rows seen in cycle n are the ROWIN driven in cycle n-2.
// ---------------------------------------------------------------------------
module tb_keypad_scan;

  logic       clk;
  logic       rst;
  logic [3:0] ROWIN;
  logic [3:0] COLSEL;
  logic [3:0] KEYCODE;
  logic       KEY_VALID;
  logic       KEY_HELD;

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ROWIN     (ROWIN),
    .COLSEL    (COLSEL),
    .KEYCODE   (KEYCODE),
    .KEY_VALID (KEY_VALID),
    .KEY_HELD  (KEY_HELD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key at (r,c) pulls row r low while column c is
  // driven. Raw mode drives ROWIN directly for glitch/chord patterns.
  logic [15:0] key_mask;
  logic        use_model;
  logic [3:0]  rowin_raw;
  logic [3:0]  rowin_model;

  always_comb begin
    rowin_model = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && !COLSEL[c]) rowin_model[r] = 1'b0;
  end

  assign ROWIN = use_model ? rowin_model : rowin_raw;

  int n_checks;
  int n_errors;
  int cyc;
  int pulses;
  int first_pulse;
  logic [3:0] kc_at_pulse;
  logic       agg_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    use_model = 1'b0;
    rowin_raw = 4'b1111;
    key_mask  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic clear_pulses();
    pulses      = 0;
    first_pulse = -1;
    kc_at_pulse = 4'h0;
  endtask

  task automatic note_pulse();
    if (KEY_VALID) begin
      pulses++;
      if (first_pulse < 0) begin
        first_pulse = cyc;
        kc_at_pulse = KEYCODE;
      end
    end
  endtask

  typedef struct {
    logic [3:0] rowin;
    logic [3:0] colsel;
    logic       valid;
    logic       held;
  } vec_t;

  vec_t vecs [24];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;

    // Idle rotation (cycles 0..15), then a rows-0-and-3 chord (cycles 16..23)
    // which must not count as a press, so rotation continues unchanged.
    vecs[0]  = '{4'b1111, 4'b1110, 1'b0, 1'b0};
    vecs[1]  = '{4'b1111, 4'b1110, 1'b0, 1'b0};
    vecs[2]  = '{4'b1111, 4'b1110, 1'b0, 1'b0};
    vecs[3]  = '{4'b1111, 4'b1110, 1'b0, 1'b0};
    vecs[4]  = '{4'b1111, 4'b1101, 1'b0, 1'b0};
    vecs[5]  = '{4'b1111, 4'b1101, 1'b0, 1'b0};
    vecs[6]  = '{4'b1111, 4'b1101, 1'b0, 1'b0};
    vecs[7]  = '{4'b1111, 4'b1101, 1'b0, 1'b0};
    vecs[8]  = '{4'b1111, 4'b1011, 1'b0, 1'b0};
    vecs[9]  = '{4'b1111, 4'b1011, 1'b0, 1'b0};
    vecs[10] = '{4'b1111, 4'b1011, 1'b0, 1'b0};
    vecs[11] = '{4'b1111, 4'b1011, 1'b0, 1'b0};
    vecs[12] = '{4'b1111, 4'b0111, 1'b0, 1'b0};
    vecs[13] = '{4'b1111, 4'b0111, 1'b0, 1'b0};
    vecs[14] = '{4'b1111, 4'b0111, 1'b0, 1'b0};
    vecs[15] = '{4'b1111, 4'b0111, 1'b0, 1'b0};
    vecs[16] = '{4'b0110, 4'b1110, 1'b0, 1'b0};
    vecs[17] = '{4'b0110, 4'b1110, 1'b0, 1'b0};
    vecs[18] = '{4'b0110, 4'b1110, 1'b0, 1'b0};
    vecs[19] = '{4'b0110, 4'b1110, 1'b0, 1'b0};
    vecs[20] = '{4'b0110, 4'b1101, 1'b0, 1'b0};
    vecs[21] = '{4'b0110, 4'b1101, 1'b0, 1'b0};
    vecs[22] = '{4'b0110, 4'b1101, 1'b0, 1'b0};
    vecs[23] = '{4'b0110, 4'b1101, 1'b0, 1'b0};

    // ---------------- Reset values, idle rotation and chord ----------------
    do_reset();
    check("reset_keycode", 32'(KEYCODE), 32'h0);
    for (int i = 0; i < 24; i++) begin
      rowin_raw = vecs[i].rowin;
      check($sformatf("vec%0d_colsel", i), 32'(COLSEL),    32'(vecs[i].colsel));
      check($sformatf("vec%0d_valid", i),  32'(KEY_VALID), 32'(vecs[i].valid));
      check($sformatf("vec%0d_held", i),   32'(KEY_HELD),  32'(vecs[i].held));
      tick();
    end

    // Single key row 3 / col 0 after the chord: col 0 returns at cycle 32,
    // first valid sample at 35, second at 39, pulse visible in cycle 40.
    use_model = 1'b1;
    key_mask  = 16'h1000;
    clear_pulses();
    while (cyc < 50) begin
      note_pulse();
      tick();
    end
    check("chord_then_c_pulses",  32'(pulses),      32'd1);
    check("chord_then_c_cycle",   32'(first_pulse), 32'd40);
    check("chord_then_c_keycode", 32'(kc_at_pulse), 32'hC);
    check("chord_then_c_held",    32'(KEY_HELD),    32'd1);
    check("chord_then_c_colsel",  32'(COLSEL),      32'(4'b1110));

    // ---------------- Clean press row 2 / col 2, hold, release -------------
    // Col 2 driven in cycles 8..11, first sample 11, accept at 15 -> pulse 16.
    // Key released at cycle 100: all-high samples at 103 and 107 -> HELD
    // drops in cycle 108 and rotation resumes at column 3.
    do_reset();
    use_model = 1'b1;
    key_mask  = 16'h0400;
    clear_pulses();
    agg_ok = 1'b1;
    while (cyc < 108) begin
      if (cyc == 100) key_mask = 16'h0000;
      note_pulse();
      if (cyc >= 8 && COLSEL !== 4'b1011) agg_ok = 1'b0;
      if (cyc == 16) begin
        check("press_keycode_at_pulse", 32'(KEYCODE),  32'hA);
        check("press_held_at_pulse",    32'(KEY_HELD), 32'd1);
      end
      if (cyc == 15) check("press_valid_before", 32'(KEY_VALID), 32'd0);
      if (cyc == 107) check("release_held_last_sample", 32'(KEY_HELD), 32'd1);
      tick();
    end
    check("press_pulse_count", 32'(pulses),      32'd1);
    check("press_latency",     32'(first_pulse), 32'd16);
    check("press_col_frozen",  32'(agg_ok),      32'd1);
    check("release_held",      32'(KEY_HELD),    32'd0);
    check("release_colsel",    32'(COLSEL),      32'(4'b0111));
    check("release_keycode",   32'(KEYCODE),     32'hA);
    repeat (4) tick();
    check("release_rotate",    32'(COLSEL),      32'(4'b1110));

    // ---------------- Bounce: row 1 low for a single sample ----------------
    // Raw row 1 low in cycles 4..7 is seen only by the sample at 7 (col 1);
    // the sample at 11 sees all high, so scanning resumes at col 2 in 12.
    do_reset();
    clear_pulses();
    while (cyc < 24) begin
      rowin_raw = (cyc >= 4 && cyc < 8) ? 4'b1101 : 4'b1111;
      note_pulse();
      if (cyc == 9)  check("bounce_frozen_col1", 32'(COLSEL), 32'(4'b1101));
      if (cyc == 12) check("bounce_resume_col2", 32'(COLSEL), 32'(4'b1011));
      if (cyc == 12) check("bounce_held",        32'(KEY_HELD), 32'd0);
      tick();
    end
    check("bounce_pulses", 32'(pulses), 32'd0);

    // ---------------- Reset in the middle of DEBOUNCE ----------------------
    do_reset();
    use_model = 1'b1;
    key_mask  = 16'h0400;
    clear_pulses();
    while (cyc < 13) begin
      note_pulse();
      tick();
    end
    check("mid_deb_frozen", 32'(COLSEL), 32'(4'b1011));
    rst      = 1'b0;
    key_mask = 16'h0000;
    #1;
    check("mid_deb_rst_colsel",  32'(COLSEL),    32'(4'b1110));
    check("mid_deb_rst_held",    32'(KEY_HELD),  32'd0);
    check("mid_deb_rst_valid",   32'(KEY_VALID), 32'd0);
    check("mid_deb_rst_keycode", 32'(KEYCODE),   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    agg_ok = 1'b1;
    while (cyc < 24) begin
      note_pulse();
      if (cyc < 4 && COLSEL !== 4'b1110) agg_ok = 1'b0;
      if (cyc == 4) check("mid_deb_full_dwell_next", 32'(COLSEL), 32'(4'b1101));
      tick();
    end
    check("mid_deb_full_dwell_col0", 32'(agg_ok), 32'd1);
    check("mid_deb_pulses",          32'(pulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_keypad_scan
